// File: rtl/fbcpu_pkg.sv
// Shared definitions for the FBCPU memory checker: FSM state encoding and
// width helpers for the counters and check-index fields.
package fbcpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CMP   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = int'($clog2(n));
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned run_cycles);
        return clog2_min1(run_cycles + 1);
    endfunction

    function automatic int unsigned idx_w(input int unsigned num_checks);
        return clog2_min1(num_checks);
    endfunction

    function automatic int unsigned fcnt_w(input int unsigned num_checks);
        return clog2_min1(num_checks + 1);
    endfunction

endpackage

// File: rtl/fbcpu_cycle_counter.sv
// Up-counter with synchronous clear (priority over enable) and a flag that is
// high while the count equals TERMINAL.
module fbcpu_cycle_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TERMINAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/fbcpu_mem_checker.sv
// Runs the CPU for a bounded number of cycles (or until halt), then reads and
// compares a table of RAM locations and reports pass/fail and failure details.
module fbcpu_mem_checker
    import fbcpu_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 6,
    parameter int unsigned DATA_WIDTH    = 10,
    parameter int unsigned NUM_CHECKS    = 4,
    parameter int unsigned RUN_CYCLES    = 10000,
    parameter int unsigned READ_LATENCY  = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_start,
    input  logic                                  i_halt,
    input  logic [NUM_CHECKS*ADDRESS_WIDTH-1:0]   i_chk_addr,
    input  logic [NUM_CHECKS*DATA_WIDTH-1:0]      i_chk_data,
    input  logic [NUM_CHECKS-1:0]                 i_chk_en,
    output logic                                  o_rd_en,
    output logic [ADDRESS_WIDTH-1:0]              o_rd_addr,
    input  logic [DATA_WIDTH-1:0]                 i_rd_data,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_pass,
    output logic [idx_w(NUM_CHECKS)-1:0]          o_fail_idx,
    output logic [fcnt_w(NUM_CHECKS)-1:0]         o_fail_cnt,
    output logic [cnt_w(RUN_CYCLES)-1:0]          o_cycle_cnt
);

    localparam int unsigned CNT_W   = cnt_w(RUN_CYCLES);
    localparam int unsigned IDX_W   = idx_w(NUM_CHECKS);
    localparam int unsigned FCNT_W  = fcnt_w(NUM_CHECKS);
    localparam int unsigned WAIT_W  = clog2_min1(READ_LATENCY);
    // WAIT holds READ_LATENCY-1 cycles; the counter starts at 0 on entry.
    localparam int unsigned WAIT_TC = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [FCNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [IDX_W-1:0]    fail_idx_q, fail_idx_d;
    logic                fail_found_q, fail_found_d;

    logic                run_clr, run_tc;
    logic [CNT_W-1:0]    run_cnt;
    logic                wait_tc;
    logic [WAIT_W-1:0]   wait_cnt_unused;

    logic [ADDRESS_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0]    cur_data;

    assign cur_addr = i_chk_addr[idx_q*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign cur_data = i_chk_data[idx_q*DATA_WIDTH +: DATA_WIDTH];

    fbcpu_cycle_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (RUN_CYCLES - 1)
    ) u_run_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (run_clr),
        .en_i  (state_q == ST_RUN),
        .cnt_o (run_cnt),
        .tc_o  (run_tc)
    );

    fbcpu_cycle_counter #(
        .WIDTH    (WAIT_W),
        .TERMINAL (WAIT_TC)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (state_q == ST_ISSUE),
        .en_i  (state_q == ST_WAIT),
        .cnt_o (wait_cnt_unused),
        .tc_o  (wait_tc)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fail_cnt_d   = fail_cnt_q;
        fail_idx_d   = fail_idx_q;
        fail_found_d = fail_found_q;
        run_clr      = 1'b0;
        o_rd_en      = 1'b0;
        o_rd_addr    = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d      = ST_RUN;
                    run_clr      = 1'b1;
                    idx_d        = '0;
                    fail_cnt_d   = '0;
                    fail_idx_d   = '0;
                    fail_found_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (i_halt || run_tc) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!i_chk_en[idx_q]) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    o_rd_en   = 1'b1;
                    o_rd_addr = cur_addr;
                    state_d   = (READ_LATENCY > 1) ? ST_WAIT : ST_CMP;
                end
            end
            ST_WAIT: begin
                if (wait_tc) begin
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                if (i_rd_data != cur_data) begin
                    if (fail_cnt_q != '1) begin
                        fail_cnt_d = fail_cnt_q + 1'b1;
                    end
                    if (!fail_found_q) begin
                        fail_found_d = 1'b1;
                        fail_idx_d   = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            fail_cnt_q   <= '0;
            fail_idx_q   <= '0;
            fail_found_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            fail_cnt_q   <= fail_cnt_d;
            fail_idx_q   <= fail_idx_d;
            fail_found_q <= fail_found_d;
        end
    end

    assign o_busy      = (state_q == ST_RUN) || (state_q == ST_ISSUE) ||
                         (state_q == ST_WAIT) || (state_q == ST_CMP);
    assign o_done      = (state_q == ST_DONE);
    assign o_pass      = (state_q == ST_DONE) && (fail_cnt_q == '0);
    assign o_fail_idx  = fail_idx_q;
    assign o_fail_cnt  = fail_cnt_q;
    assign o_cycle_cnt = run_cnt;

endmodule

// File: tb/tb_fbcpu_mem_checker.sv
// Directed bench for fbcpu_mem_checker: one instance with RUN_CYCLES=100 and
// single-cycle reads, one with RUN_CYCLES=10000 and a 3-cycle read pipeline.
module tb_fbcpu_mem_checker;

    localparam int AW = 6;
    localparam int DW = 10;
    localparam int N  = 4;
    localparam logic [DW-1:0] POISON = 10'h2AA;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start_a = 1'b0, start_b = 1'b0, halt = 1'b0;
    logic [N*AW-1:0] chk_addr = '0;
    logic [N*DW-1:0] chk_data = '0;
    logic [N-1:0]    chk_en   = '0;

    logic          rd_en_a, rd_en_b;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [1:0]    fidx_a, fidx_b;
    logic [2:0]    fcnt_a, fcnt_b;
    logic [6:0]    cyc_a;
    logic [13:0]   cyc_b;

    fbcpu_mem_checker #(
        .ADDRESS_WIDTH (AW), .DATA_WIDTH (DW), .NUM_CHECKS (N),
        .RUN_CYCLES (100), .READ_LATENCY (1)
    ) dut_a (
        .clk (clk), .rst (rst), .i_start (start_a), .i_halt (halt),
        .i_chk_addr (chk_addr), .i_chk_data (chk_data), .i_chk_en (chk_en),
        .o_rd_en (rd_en_a), .o_rd_addr (rd_addr_a), .i_rd_data (rd_data_a),
        .o_busy (busy_a), .o_done (done_a), .o_pass (pass_a),
        .o_fail_idx (fidx_a), .o_fail_cnt (fcnt_a), .o_cycle_cnt (cyc_a)
    );

    fbcpu_mem_checker #(
        .ADDRESS_WIDTH (AW), .DATA_WIDTH (DW), .NUM_CHECKS (N),
        .RUN_CYCLES (10000), .READ_LATENCY (3)
    ) dut_b (
        .clk (clk), .rst (rst), .i_start (start_b), .i_halt (halt),
        .i_chk_addr (chk_addr), .i_chk_data (chk_data), .i_chk_en (chk_en),
        .o_rd_en (rd_en_b), .o_rd_addr (rd_addr_b), .i_rd_data (rd_data_b),
        .o_busy (busy_b), .o_done (done_b), .o_pass (pass_b),
        .o_fail_idx (fidx_b), .o_fail_cnt (fcnt_b), .o_cycle_cnt (cyc_b)
    );

    // RAM models: data is valid only on the exact latency cycle, poison otherwise.
    logic [DW-1:0] ram [64];
    logic          pa_v = 1'b0;
    logic [DW-1:0] pa_d = '0;
    logic          pb_v0 = 1'b0, pb_v1 = 1'b0, pb_v2 = 1'b0;
    logic [DW-1:0] pb_d0 = '0, pb_d1 = '0, pb_d2 = '0;

    always @(posedge clk) begin
        pa_v  <= rd_en_a;
        pa_d  <= ram[rd_addr_a];
        pb_v0 <= rd_en_b;
        pb_d0 <= ram[rd_addr_b];
        pb_v1 <= pb_v0;
        pb_d1 <= pb_d0;
        pb_v2 <= pb_v1;
        pb_d2 <= pb_d1;
    end
    assign rd_data_a = pa_v  ? pa_d  : POISON;
    assign rd_data_b = pb_v2 ? pb_d2 : POISON;

    logic          sel_b = 1'b0;
    logic          mon_rd_en, mon_busy, mon_done, mon_pass;
    logic [AW-1:0] mon_rd_addr;
    logic [1:0]    mon_fidx;
    logic [2:0]    mon_fcnt;
    logic [13:0]   mon_cyc;

    always_comb begin
        mon_rd_en   = sel_b ? rd_en_b   : rd_en_a;
        mon_rd_addr = sel_b ? rd_addr_b : rd_addr_a;
        mon_busy    = sel_b ? busy_b    : busy_a;
        mon_done    = sel_b ? done_b    : done_a;
        mon_pass    = sel_b ? pass_b    : pass_a;
        mon_fidx    = sel_b ? fidx_b    : fidx_a;
        mon_fcnt    = sel_b ? fcnt_b    : fcnt_a;
        mon_cyc     = sel_b ? cyc_b     : {7'd0, cyc_a};
    end

    typedef struct {
        logic            use_b;
        int              halt_at;
        logic [N*AW-1:0] addr;
        logic [N*DW-1:0] exp;
        logic [N*DW-1:0] mem;
        logic [N-1:0]    en;
        int              cyc;
        int              nrd;
        logic            pass;
        int              fcnt;
        int              fidx;
    } vec_t;

    vec_t vecs[8];
    int tests = 0;
    int fails = 0;

    function automatic logic [N*AW-1:0] pa4(input int a0, a1, a2, a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    function automatic logic [N*DW-1:0] pd4(input int d0, d1, d2, d3);
        return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int nrd     = 0;
        int first_rd = -1;
        int done_k  = -1;
        int ptr     = 0;
        int rl;
        rl = v.use_b ? 3 : 1;
        sel_b    = v.use_b;
        chk_addr = v.addr;
        chk_data = v.exp;
        chk_en   = v.en;
        for (int e = 0; e < N; e++) ram[v.addr[e*AW +: AW]] = v.mem[e*DW +: DW];
        if (v.use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        check({nm, " run-entry clear"}, {mon_busy, mon_done, mon_pass, mon_fcnt, mon_fidx}, 64'h80);
        for (int k = 0; k < 20000; k++) begin
            halt = (k == v.halt_at);
            if (mon_rd_en) begin
                while (ptr < N && !v.en[ptr]) ptr++;
                if (ptr < N) check({nm, " rd_addr"}, mon_rd_addr, v.addr[ptr*AW +: AW]);
                ptr++;
                nrd++;
                if (first_rd < 0) first_rd = k;
            end
            if (mon_done) begin
                done_k = k;
                break;
            end
            @(posedge clk); #1;
        end
        halt = 1'b0;
        check({nm, " done reached"}, done_k >= 0, 1);
        check({nm, " cycle_cnt"}, mon_cyc, v.cyc);
        check({nm, " reads"}, nrd, v.nrd);
        check({nm, " pass"}, mon_pass, v.pass);
        check({nm, " fail_cnt"}, mon_fcnt, v.fcnt);
        check({nm, " fail_idx"}, mon_fidx, v.fidx);
        check({nm, " busy at done"}, mon_busy, 0);
        check({nm, " check latency"}, (done_k - v.cyc) <= N * (rl + 1), 1);
        if (v.halt_at >= 0 && v.en[0]) check({nm, " halt to strobe"}, first_rd, v.halt_at + 1);
    endtask

    initial begin
        vec_t fixed;
        for (int i = 0; i < 64; i++) ram[i] = DW'(i);

        //            use_b halt addr                 exp                  mem                  en       cyc  nrd pass fcnt fidx
        vecs[0] = '{1'b0, -1, pa4(52, 1, 2, 3),    pd4(15, 0, 0, 0),    pd4(15, 1, 2, 3),    4'b0001, 100, 1, 1'b1, 0, 0};
        vecs[1] = '{1'b0, -1, pa4(10, 20, 30, 52), pd4(3, 8, 1, 50),    pd4(3, 7, 9, 50),    4'b1111, 100, 4, 1'b0, 2, 1};
        vecs[2] = '{1'b1, 37, pa4(10, 20, 30, 52), pd4(3, 7, 9, 50),    pd4(3, 7, 9, 50),    4'b1111, 38,  4, 1'b1, 0, 0};
        vecs[3] = '{1'b1, 5,  pa4(10, 20, 30, 52), pd4(5, 7, 1, 49),    pd4(3, 7, 9, 50),    4'b1010, 6,   2, 1'b0, 1, 3};
        vecs[4] = '{1'b1, 0,  pa4(10, 20, 30, 52), pd4(5, 8, 1, 49),    pd4(3, 7, 9, 50),    4'b0000, 1,   0, 1'b1, 0, 0};
        vecs[5] = '{1'b0, 99, pa4(10, 20, 30, 52), pd4(3, 7, 9, 50),    pd4(3, 7, 9, 50),    4'b0100, 100, 1, 1'b1, 0, 0};
        vecs[6] = '{1'b0, 0,  pa4(10, 20, 30, 52), pd4(4, 7, 9, 50),    pd4(3, 7, 9, 50),    4'b0001, 1,   1, 1'b0, 1, 0};
        vecs[7] = '{1'b0, 3,  pa4(10, 20, 30, 52), pd4(0, 0, 0, 0),     pd4(3, 7, 9, 50),    4'b1111, 4,   4, 1'b0, 4, 0};

        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs A", {rd_en_a, rd_addr_a, busy_a, done_a, pass_a, fidx_a, fcnt_a, cyc_a}, 0);
        check("reset outputs B", {rd_en_b, rd_addr_b, busy_b, done_b, pass_b, fidx_b, fcnt_b, cyc_b}, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Async reset while instance B sits in WAIT.
        sel_b    = 1'b1;
        chk_addr = vecs[2].addr;
        chk_data = vecs[2].exp;
        chk_en   = vecs[2].en;
        start_b  = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            halt = (k == 2);
            if (k == 3) check("mid-wait strobe", rd_en_b, 1);
            @(posedge clk); #1;
        end
        halt = 1'b0;
        check("mid-wait busy", {busy_b, rd_en_b}, 2'b10);
        #2 rst = 1'b0;
        #1;
        check("async reset outputs B", {rd_en_b, rd_addr_b, busy_b, done_b, pass_b, fidx_b, fcnt_b, cyc_b}, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[2], "rerun after reset");

        // Failing run, results held in DONE, then restart with RAM fixed.
        run_vec(vecs[1], "restart first");
        repeat (3) @(posedge clk);
        #1;
        check("done hold", {done_a, pass_a, fcnt_a, fidx_a}, {1'b1, 1'b0, 3'd2, 2'd1});
        fixed      = vecs[1];
        fixed.mem  = pd4(3, 8, 1, 50);
        fixed.pass = 1'b1;
        fixed.fcnt = 0;
        fixed.fidx = 0;
        run_vec(fixed, "restart second");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
